// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants, FSM state type and request legality helper.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_t;

   // A request this slave cannot serve: reserved burst, size wider than 64 bits,
   // or a WRAP whose length is not 2/4/8/16 beats.
   function automatic logic req_illegal(input logic [1:0] burst,
                                        input logic [2:0] size,
                                        input logic [7:0] len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address generator for FIXED / INCR / WRAP bursts.
module axi_burst_addr
   import axi_pkg::*;
(
   input  logic [63:0] i_addr,
   input  logic [1:0]  i_burst,
   input  logic [2:0]  i_size,
   input  logic [7:0]  i_len,
   output logic [63:0] o_next_addr_c
);

   logic [63:0] w_step;
   logic [63:0] w_mask;

   // Step is one transfer size; wrap window is the whole burst length in bytes.
   always_comb begin
      w_step        = 64'd1 << i_size;
      w_mask        = ((64'(i_len) + 64'd1) << i_size) - 64'd1;
      o_next_addr_c = i_addr;
      case (i_burst)
         BURST_FIXED: o_next_addr_c = i_addr;
         BURST_INCR:  o_next_addr_c = i_addr + w_step;
         BURST_WRAP:  o_next_addr_c = (i_addr & ~w_mask) | ((i_addr + w_step) & w_mask);
         default:     o_next_addr_c = i_addr;
      endcase
   end

endmodule

// File: rtl/axi_imem_slave.sv
// AXI read-only instruction memory slave: one outstanding burst, fixed latency,
// 64-bit words with a side preload port.
// Build option: IMEM_RANGE_CHECK_EN enables per-beat DECERR for addresses
// outside [BASE_ADDR, BASE_ADDR+DEPTH*8); otherwise the index wraps mod DEPTH.
module axi_imem_slave
   import axi_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned LATENCY   = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [3:0]               ARID,
   input  logic [63:0]              ARADDR,
   input  logic [7:0]               ARLEN,
   input  logic [2:0]               ARSIZE,
   input  logic [1:0]               ARBURST,
   input  logic                     ARLOCK,
   input  logic [3:0]               ARCACHE,
   input  logic [2:0]               ARPORT,
   input  logic [3:0]               ARQOS,
   input  logic [3:0]               ARREGION,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   output logic [3:0]               RID,
   output logic [63:0]              RDATA,
   output logic [1:0]               RRESP,
   output logic                     RLAST,
   output logic                     RVALID,
   input  logic                     RREADY,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [63:0]              ld_data
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

   logic [63:0] r_mem [DEPTH];

   state_t      r_state, w_state_nxt;
   logic        r_arready, r_rvalid, r_rlast, r_err;
   logic [3:0]  r_id, r_lat_cnt;
   logic [63:0] r_addr, r_rdata;
   logic [1:0]  r_rresp, r_burst;
   logic [7:0]  r_len, r_beat;
   logic [2:0]  r_size;

   logic        w_ar_hs, w_load, w_done, w_oor;
   logic [63:0] w_next_addr, w_ld_addr, w_off, w_beat_data;
   logic [7:0]  w_beat_nxt;
   logic [1:0]  w_beat_resp;
   logic        w_unused;

   assign w_unused = &{1'b0, ARLOCK, ARCACHE, ARPORT, ARQOS, ARREGION, w_off};

   axi_burst_addr u_burst_addr (
      .i_addr        (r_addr),
      .i_burst       (r_burst),
      .i_size        (r_size),
      .i_len         (r_len),
      .o_next_addr_c (w_next_addr)
   );

   // Preload write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (ld_we) r_mem[ld_addr] <= ld_data;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_ar_hs     = 1'b0;
      w_load      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_arready && ARVALID) begin
               w_ar_hs     = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (r_lat_cnt == 4'd0) begin
               w_load      = 1'b1;
               w_state_nxt = BURST;
            end
         end
         BURST: begin
            if (r_rvalid && RREADY) begin
               if (r_rlast) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address, response and data of the beat about to be registered.
   always_comb begin
      w_ld_addr  = (r_state == WAIT) ? r_addr : w_next_addr;
      w_beat_nxt = (r_state == WAIT) ? 8'd0 : (r_beat + 8'd1);
      w_off      = w_ld_addr - BASE_ADDR;
`ifdef IMEM_RANGE_CHECK_EN
      w_oor      = (w_ld_addr < BASE_ADDR) || (w_off[63:3] >= 61'(DEPTH));
`else
      w_oor      = 1'b0;
`endif
      w_beat_resp = r_err ? RESP_SLVERR : (w_oor ? RESP_DECERR : RESP_OKAY);
      w_beat_data = (r_err || w_oor) ? 64'd0 : r_mem[w_off[AW+2:3]];
   end

   // Request latch, latency counter and registered R channel.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= 64'd0;
         r_id      <= 4'd0;
         r_addr    <= 64'd0;
         r_len     <= 8'd0;
         r_size    <= 3'd0;
         r_burst   <= 2'd0;
         r_err     <= 1'b0;
         r_lat_cnt <= 4'd0;
         r_beat    <= 8'd0;
      end else begin
         r_arready <= (w_state_nxt == IDLE);
         if (w_ar_hs) begin
            r_id      <= ARID;
            r_addr    <= ARADDR;
            r_len     <= ARLEN;
            r_size    <= ARSIZE;
            r_burst   <= ARBURST;
            r_err     <= req_illegal(ARBURST, ARSIZE, ARLEN);
            r_lat_cnt <= LAT_INIT;
            r_beat    <= 8'd0;
         end else if ((r_state == WAIT) && (r_lat_cnt != 4'd0)) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end
         if (w_load) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rlast  <= (w_beat_nxt == r_len);
            r_beat   <= w_beat_nxt;
            if (r_state == BURST) r_addr <= w_next_addr;
         end
         if (w_done) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   assign ARREADY = r_arready;
   assign RVALID  = r_rvalid;
   assign RLAST   = r_rlast;
   assign RRESP   = r_rresp;
   assign RDATA   = r_rdata;
   assign RID     = r_id;

endmodule

// File: tb/tb_axi_imem_slave.sv
// Directed self-checking bench for axi_imem_slave (DEPTH=8, LATENCY=2).
module tb_axi_imem_slave;

   localparam logic [63:0] BASE = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  ARID;
   logic [63:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARLOCK;
   logic [3:0]  ARCACHE;
   logic [2:0]  ARPORT;
   logic [3:0]  ARQOS;
   logic [3:0]  ARREGION;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic        ld_we;
   logic [2:0]  ld_addr;
   logic [63:0] ld_data;

   logic [63:0] mem_m [8];
   int n_vec = 0;
   int n_bad = 0;

   axi_imem_slave #(.BASE_ADDR(BASE), .DEPTH(8), .LATENCY(2)) dut (
      .clk(clk), .rstn(rstn),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARQOS(ARQOS), .ARREGION(ARREGION),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one AR request and return just after its handshake edge.
   task automatic ar_issue(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      int k;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARLOCK = 1'($urandom); ARCACHE = 4'($urandom); ARPORT = 3'($urandom);
      ARQOS = 4'($urandom); ARREGION = 4'($urandom);
      ARVALID = 1'b1;
      for (k = 0; k < 20; k++) begin
         if (ARREADY) break;
         tick();
      end
      n_vec++;
      if (k == 20) begin
         n_bad++;
         $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
      end
      tick();
      ARVALID = 1'b0;
   endtask

   // Wait (bounded) for a valid beat and hand back what is on the R channel.
   task automatic wait_beat(output logic [63:0] d, output logic [1:0] r,
                            output logic l, output logic [3:0] id);
      int k;
      for (k = 0; k < 30; k++) begin
         if (RVALID) break;
         tick();
      end
      n_vec++;
      if (k == 30) begin
         n_bad++;
         $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
      end
      d = RDATA; r = RRESP; l = RLAST; id = RID;
   endtask

   task automatic accept;
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0; ld_we = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
      ARLOCK = 1'b0; ARCACHE = '0; ARPORT = '0; ARQOS = '0; ARREGION = '0;
      ld_addr = '0; ld_data = '0;
      tick();
      for (int i = 0; i < 8; i++) begin
         mem_m[i] = (i == 0) ? 64'h0000_0013_0000_0297 : {{8{4'(i)}}, 32'(i)};
         ld_we = 1'b1; ld_addr = 3'(i); ld_data = mem_m[i];
         tick();
      end
      ld_we = 1'b0;
      n_vec++;
      if ({ARREADY, RVALID, RLAST, RRESP, RID, RDATA} !== 73'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: ARREADY=%b RVALID=%b RLAST=%b RRESP=%b RID=%h RDATA=%h required all 0",
                  ARREADY, RVALID, RLAST, RRESP, RID, RDATA);
      end
      rstn = 1'b1;
      tick();
      n_vec++;
      if (ARREADY !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_arready_rise: ARREADY=%b required 1", ARREADY);
      end
   endtask

   task automatic test_single;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      ar_issue(4'h1, BASE, 8'd0, 3'd3, 2'b01);
      n_vec++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
         n_bad++;
         $display("FAIL single_lat0: RVALID=%b ARREADY=%b required 0 0", RVALID, ARREADY);
      end
      tick();
      n_vec++;
      if (RVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL single_lat1: RVALID=%b required 0", RVALID);
      end
      tick();
      n_vec++;
      if (RVALID !== 1'b1) begin
         n_bad++;
         $display("FAIL single_lat2: RVALID=%b required 1", RVALID);
      end
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== 64'h0000_0013_0000_0297 || r !== 2'b00 || l !== 1'b1 || id !== 4'h1) begin
         n_bad++;
         $display("FAIL single_beat: data=%h resp=%b last=%b id=%h required 0000001300000297 00 1 1",
                  d, r, l, id);
      end
      accept();
      n_vec++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
         n_bad++;
         $display("FAIL single_end: RVALID=%b ARREADY=%b required 0 1", RVALID, ARREADY);
      end
   endtask

   task automatic test_incr_stall;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      ar_issue(4'h3, BASE + 64'h8, 8'd3, 3'd3, 2'b01);
      for (int b = 0; b < 4; b++) begin
         wait_beat(d, r, l, id);
         n_vec++;
         if (d !== mem_m[b+1] || r !== 2'b00 || l !== (b == 3) || id !== 4'h3) begin
            n_bad++;
            $display("FAIL incr_beat%0d: data=%h resp=%b last=%b id=%h required %h 00 %b 3",
                     b, d, r, l, id, mem_m[b+1], (b == 3));
         end
         if (b % 2 == 1) begin
            tick(); tick();
            n_vec++;
            if (RVALID !== 1'b1 || RDATA !== d || RLAST !== l || RRESP !== r) begin
               n_bad++;
               $display("FAIL incr_stall%0d: valid=%b data=%h last=%b required 1 %h %b",
                        b, RVALID, RDATA, RLAST, d, l);
            end
         end
         accept();
      end
      n_vec++;
      if (RVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL incr_end: RVALID=%b required 0", RVALID);
      end
   endtask

   task automatic test_wrap;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      int order [4] = '{2, 3, 0, 1};
      ar_issue(4'h2, BASE + 64'h10, 8'd3, 3'd3, 2'b10);
      for (int b = 0; b < 4; b++) begin
         wait_beat(d, r, l, id);
         n_vec++;
         if (d !== mem_m[order[b]] || r !== 2'b00 || l !== (b == 3)) begin
            n_bad++;
            $display("FAIL wrap_beat%0d: data=%h resp=%b last=%b required %h 00 %b",
                     b, d, r, l, mem_m[order[b]], (b == 3));
         end
         accept();
      end
   endtask

   task automatic test_fixed_narrow;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      int nidx [4] = '{0, 0, 1, 1};
      ar_issue(4'h4, BASE + 64'h20, 8'd2, 3'd3, 2'b00);
      for (int b = 0; b < 3; b++) begin
         wait_beat(d, r, l, id);
         n_vec++;
         if (d !== mem_m[4] || r !== 2'b00 || l !== (b == 2)) begin
            n_bad++;
            $display("FAIL fixed_beat%0d: data=%h resp=%b last=%b required %h 00 %b",
                     b, d, r, l, mem_m[4], (b == 2));
         end
         accept();
      end
      ar_issue(4'h4, BASE, 8'd3, 3'd2, 2'b01);
      for (int b = 0; b < 4; b++) begin
         wait_beat(d, r, l, id);
         n_vec++;
         if (d !== mem_m[nidx[b]] || r !== 2'b00 || l !== (b == 3)) begin
            n_bad++;
            $display("FAIL narrow_beat%0d: data=%h resp=%b last=%b required %h 00 %b",
                     b, d, r, l, mem_m[nidx[b]], (b == 3));
         end
         accept();
      end
   endtask

   task automatic test_slverr;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      logic [7:0] lens   [3] = '{8'd1, 8'd0, 8'd2};
      logic [2:0] sizes  [3] = '{3'd3, 3'd4, 3'd3};
      logic [1:0] bursts [3] = '{2'b11, 2'b01, 2'b10};
      for (int t = 0; t < 3; t++) begin
         ar_issue(4'h7, BASE + 64'h8, lens[t], sizes[t], bursts[t]);
         for (int b = 0; b <= int'(lens[t]); b++) begin
            wait_beat(d, r, l, id);
            n_vec++;
            if (d !== 64'd0 || r !== 2'b10 || l !== (b == int'(lens[t]))) begin
               n_bad++;
               $display("FAIL slverr%0d_beat%0d: data=%h resp=%b last=%b required 0 10 %b",
                        t, b, d, r, l, (b == int'(lens[t])));
            end
            accept();
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      ar_issue(4'h5, BASE, 8'd7, 3'd3, 2'b01);
      for (int b = 0; b < 2; b++) begin
         wait_beat(d, r, l, id);
         accept();
      end
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== mem_m[2]) begin
         n_bad++;
         $display("FAIL rstmid_beat2: data=%h required %h", d, mem_m[2]);
      end
      rstn = 1'b0;
      tick();
      n_vec++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_abort: RVALID=%b ARREADY=%b required 0 0", RVALID, ARREADY);
      end
      rstn = 1'b1;
      tick();
      n_vec++;
      if (ARREADY !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_arready: ARREADY=%b required 1", ARREADY);
      end
      RREADY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_vec++;
         if (RVALID !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_noresid%0d: RVALID=%b required 0", k, RVALID);
         end
      end
      RREADY = 1'b0;
      ar_issue(4'h6, BASE + 64'h18, 8'd0, 3'd3, 2'b01);
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== mem_m[3] || r !== 2'b00 || l !== 1'b1 || id !== 4'h6) begin
         n_bad++;
         $display("FAIL rstmid_next: data=%h resp=%b last=%b id=%h required %h 00 1 6",
                  d, r, l, id, mem_m[3]);
      end
      accept();
   endtask

   task automatic test_range;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      logic [63:0] exp_d; logic [1:0] exp_r;
`ifdef IMEM_RANGE_CHECK_EN
      exp_d = 64'd0; exp_r = 2'b11;
`else
      exp_d = mem_m[0]; exp_r = 2'b00;
`endif
      ar_issue(4'h8, BASE + 64'h38, 8'd1, 3'd3, 2'b01);
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== mem_m[7] || r !== 2'b00 || l !== 1'b0) begin
         n_bad++;
         $display("FAIL range_beat0: data=%h resp=%b last=%b required %h 00 0", d, r, l, mem_m[7]);
      end
      accept();
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== exp_d || r !== exp_r || l !== 1'b1) begin
         n_bad++;
         $display("FAIL range_beat1: data=%h resp=%b last=%b required %h %b 1", d, r, l, exp_d, exp_r);
      end
      accept();
   endtask

   task automatic test_back_to_back;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      ar_issue(4'hA, BASE + 64'h8, 8'd1, 3'd3, 2'b01);
      ARID = 4'h6; ARADDR = BASE + 64'h30; ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01;
      ARVALID = 1'b1;
      for (int b = 0; b < 2; b++) begin
         wait_beat(d, r, l, id);
         n_vec++;
         if (id !== 4'hA || d !== mem_m[b+1] || l !== (b == 1) || ARREADY !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_beat%0d: id=%h data=%h last=%b arready=%b required a %h %b 0",
                     b, id, d, l, ARREADY, mem_m[b+1], (b == 1));
         end
         accept();
      end
      n_vec++;
      if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_gap: ARREADY=%b RVALID=%b required 1 0", ARREADY, RVALID);
      end
      tick();
      ARVALID = 1'b0;
      wait_beat(d, r, l, id);
      n_vec++;
      if (id !== 4'h6 || d !== mem_m[6] || l !== 1'b1 || r !== 2'b00) begin
         n_bad++;
         $display("FAIL b2b_second: id=%h data=%h last=%b resp=%b required 6 %h 1 00",
                  id, d, l, r, mem_m[6]);
      end
      accept();
   endtask

   task automatic test_ld_collision;
      logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
      logic [63:0] old_v;
      old_v = mem_m[5];
      ar_issue(4'h9, BASE + 64'h28, 8'd0, 3'd3, 2'b01);
      tick();
      ld_we = 1'b1; ld_addr = 3'd5; ld_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      ld_we = 1'b0;
      mem_m[5] = 64'hDEAD_BEEF_CAFE_F00D;
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== old_v) begin
         n_bad++;
         $display("FAIL collide_old: data=%h required %h", d, old_v);
      end
      accept();
      ar_issue(4'h9, BASE + 64'h28, 8'd0, 3'd3, 2'b01);
      wait_beat(d, r, l, id);
      n_vec++;
      if (d !== mem_m[5]) begin
         n_bad++;
         $display("FAIL collide_new: data=%h required %h", d, mem_m[5]);
      end
      accept();
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr_stall();
      test_wrap();
      test_fixed_narrow();
      test_slverr();
      test_reset_mid();
      test_range();
      test_back_to_back();
      test_ld_collision();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_imem_slave.md
AXI_IMEM_SLAVE -- requirements
Module: axi_imem_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH, default 4096, number of 64-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from AR handshake to first RVALID (legal range 1..15).
REQ-004 SHALL have ports: clk input 1, system clock; rstn input 1, synchronous active-low reset.
REQ-005 SHALL have ports: ARID in 4, ARADDR in 64, ARLEN in 8, ARSIZE in 3, ARBURST in 2; AR request fields.
REQ-006 SHALL have ports: ARLOCK in 1, ARCACHE in 4, ARPORT in 3, ARQOS in 4, ARREGION in 4; accepted and ignored.
REQ-007 SHALL have ports: ARVALID in 1, ARREADY out 1; address handshake.
REQ-008 SHALL have ports: RID out 4, RDATA out 64, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1; read data channel.
REQ-009 SHALL have ports: ld_we in 1, ld_addr in log2(DEPTH), ld_data in 64; word preload write port.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-011 IDLE: ARREADY=1; on ARVALID&ARREADY, latch ARID/ARADDR/ARLEN/ARSIZE/ARBURST, load latency counter with LATENCY-1, go to WAIT.
REQ-012 WAIT: ARREADY=0; count down; at 0 go to BURST with RVALID=1 and first beat registered in the same edge.
REQ-013 BURST: RVALID held high with RDATA/RRESP/RLAST/RID stable until RREADY; on RVALID&RREADY advance beat.
REQ-014 Beat counter runs 0..ARLEN; RLAST=1 only on beat ARLEN; handshake on RLAST returns to IDLE, RVALID=0 next cycle.
REQ-015 One outstanding transaction; no AR accepted outside IDLE; ARREADY registered, no combinational path from ARVALID.
REQ-016 RID SHALL equal latched ARID for every beat.
REQ-017 Beat address: FIXED(00) constant; INCR(01) add 1<<ARSIZE; WRAP(10) wrap within boundary (ARLEN+1)<<ARSIZE aligned down.
REQ-018 RDATA SHALL be the full 64-bit word at ((addr-BASE_ADDR)>>3); narrow sizes return the whole word, the master selects lanes.
REQ-019 ARBURST=11, ARSIZE>3, or WRAP with ARLEN not in {1,3,7,15}: every beat RRESP=2'b10 (SLVERR), RDATA=0, beat count still ARLEN+1.
REQ-020 Otherwise RRESP=2'b00 unless REQ-030 applies.
REQ-021 ld_we writes ld_data at ld_addr on the clock edge; a same-cycle read of that word returns the old value.
REQ-022 RREADY held low SHALL stall indefinitely without data loss or counter advance.

Reset
REQ-023 rstn low at a clock edge: state IDLE, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, counters 0.
REQ-024 ARREADY SHALL rise the first cycle after rstn deasserts.
REQ-025 Reset mid-WAIT or mid-BURST SHALL abandon the transaction; no further beats are issued for it.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro IMEM_RANGE_CHECK_EN SHALL select address range checking.
REQ-028 Without it, word index = ((addr-BASE_ADDR)>>3) mod DEPTH; RRESP never 11.
REQ-029 With it, each beat address is checked independently against [BASE_ADDR, BASE_ADDR+DEPTH*8).
REQ-030 With it, an out-of-range beat returns RRESP=2'b11 (DECERR) and RDATA=0; in-range beats of the same burst stay OKAY.

Structure
REQ-031 Shared package axi_pkg SHALL hold the BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR/DECERR constants and the FSM state typedef.
REQ-032 Sub-module axi_burst_addr (combinational next-beat address for FIXED/INCR/WRAP) SHALL be used; the storage array is inline.

Verification
REQ-033 Single beat: preload word0=64'h0000_0013_0000_0297, AR addr 0x8000_0000 len0 size3 INCR; RVALID 2 cycles after handshake, RDATA matches, RLAST=1, RRESP=0.
REQ-034 INCR len3 from 0x8000_0008, RREADY toggling 1,0,1,0: words 1..4 in order, RLAST only on the 4th, data stable while stalled.
REQ-035 WRAP len3 size3 at 0x8000_0010: word order 2,3,0,1; ARBURST=11 len1: two beats RRESP=10, RDATA=0.
REQ-036 Reset asserted during beat 2 of len7 burst: RVALID=0 after the edge, ARREADY=1 one cycle after release, next AR serviced correctly.
REQ-037 With IMEM_RANGE_CHECK_EN and DEPTH=4, INCR len1 at 0x8000_0018: beat0 OKAY with word3, beat1 DECERR with 0; without the macro beat1 returns word0 with OKAY.
REQ-038 ARID=4'hA held: every beat RID=4'hA; ARVALID during BURST is not accepted until after RLAST handshake.
